// File: rtl/write_packet_scheduler.sv
// Whole-packet write scheduler: arbitrates NUM_PORTS ingress ports onto the
// shared SRAM write path, by strict priority or weighted round-robin, and
// holds the grant for the full packet followed by a one-cycle release gap.
module write_packet_scheduler #(
    parameter int NUM_PORTS = 16,
    parameter int PORT_W    = 4,
    parameter int LEN_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sp0_wrr1,
    input  logic [NUM_PORTS-1:0]       req,
    input  logic [NUM_PORTS*3-1:0]     priority_in,
    input  logic [NUM_PORTS*LEN_W-1:0] pkt_len,
    input  logic                       sram_ready,
    output logic [NUM_PORTS-1:0]       gnt,
    output logic [PORT_W-1:0]          select,
    output logic                       wr_en,
    output logic                       pkt_done,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t state, state_nxt;

    // per-port views of the flat priority / length buses
    logic [NUM_PORTS-1:0][2:0]       prio;
    logic [NUM_PORTS-1:0][LEN_W-1:0] len;
    assign prio = priority_in;
    assign len  = pkt_len;

    logic [LEN_W-1:0]  cnt;
    logic [PORT_W-1:0] ptr;
    logic [2:0]        cred;
    logic              mode_q;

    // arbitration results
    logic              sp_found;
    logic [PORT_W-1:0] sp_win;
    logic [2:0]        sp_best;
    logic [2:0]        cred_eff;
    logic              rr_keep;
    logic              rr_found;
    logic [PORT_W-1:0] rr_win;
    logic [PORT_W-1:0] rr_idx;
    logic [PORT_W-1:0] win;

    // strict priority: highest level wins, strict '>' keeps the lowest index on ties
    always_comb begin
        sp_found = 1'b0;
        sp_win   = '0;
        sp_best  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && (!sp_found || prio[i] > sp_best)) begin
                sp_found = 1'b1;
                sp_win   = PORT_W'(i);
                sp_best  = prio[i];
            end
        end
    end

    // weighted round-robin: stay on ptr while credit remains, else search from ptr+1,
    // visiting ptr itself last; a mode switch zeroes the credit for this decision
    always_comb begin
        cred_eff = (sp0_wrr1 != mode_q) ? 3'd0 : cred;
        rr_keep  = req[ptr] && (cred_eff != 3'd0);
        rr_found = 1'b0;
        rr_win   = ptr;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            rr_idx = PORT_W'(int'(ptr) + k);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
        win = sp0_wrr1 ? (rr_keep ? ptr : rr_win) : sp_win;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next state and beat-level outputs
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        pkt_done  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) state_nxt = XFER;
            end
            XFER: begin
                busy     = 1'b1;
                wr_en    = sram_ready;
                pkt_done = sram_ready && (cnt == LEN_W'(1));
                if (pkt_done) state_nxt = GAP;
            end
            GAP: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // grant, word counter and arbitration state
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt    <= '0;
            select <= '0;
            cnt    <= '0;
            ptr    <= PORT_W'(NUM_PORTS - 1);
            cred   <= '0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= NUM_PORTS'(1) << win;
                        select <= win;
                        cnt    <= (len[win] == '0) ? LEN_W'(1) : len[win];
                        mode_q <= sp0_wrr1;
                        if (sp0_wrr1) begin
                            if (rr_keep) begin
                                cred <= cred_eff - 3'd1;
                            end else begin
                                ptr  <= rr_win;
                                cred <= prio[rr_win];
                            end
                        end else if (sp0_wrr1 != mode_q) begin
                            cred <= '0;
                        end
                    end
                end
                XFER: begin
                    if (wr_en) cnt <= cnt - LEN_W'(1);
                    if (pkt_done) gnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_write_packet_scheduler.sv
// Scoreboard bench for write_packet_scheduler: the stimulus side predicts each
// packet's winner and length with a transaction-level model; a monitor checks
// every completed packet and the grant/gap/idle framing around it.
module tb_write_packet_scheduler;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sp0_wrr1 = 1'b0;
    logic [15:0]       req = '0;
    logic [15:0][2:0]  tb_prio = '0;
    logic [15:0][7:0]  tb_len = '0;
    logic              sram_ready = 1'b0;
    logic [15:0]       gnt;
    logic [3:0]        select;
    logic              wr_en, pkt_done, busy;

    write_packet_scheduler #(.NUM_PORTS(16), .PORT_W(4), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .req(req),
        .priority_in(tb_prio), .pkt_len(tb_len), .sram_ready(sram_ready),
        .gnt(gnt), .select(select), .wr_en(wr_en), .pkt_done(pkt_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int port; int len; } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // reference arbitration state
    int   ptr_m  = 15;
    int   cred_m = 0;
    logic mode_m = 1'b0;

    int rdy_mode = 0;  // 0 random, 1 always ready, 2 fixed toggle pattern

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ptr_m  = 15;
        cred_m = 0;
        mode_m = 1'b0;
    endfunction

    // one grant decision for a given request vector and mode
    function automatic int model_pick(input logic [15:0] r, input logic m);
        int w;
        w = -1;
        if (m != mode_m) begin
            cred_m = 0;
            mode_m = m;
        end
        if (!m) begin
            for (int p = 7; p >= 0 && w < 0; p--)
                for (int i = 0; i < 16 && w < 0; i++)
                    if (r[i] && int'(tb_prio[i]) == p) w = i;
        end else if (r[ptr_m] && cred_m > 0) begin
            cred_m--;
            w = ptr_m;
        end else begin
            for (int k = 1; k <= 16 && w < 0; k++)
                if (r[(ptr_m + k) % 16]) w = (ptr_m + k) % 16;
            ptr_m  = w;
            cred_m = int'(tb_prio[w]);
        end
        return w;
    endfunction

    // drive inputs for k packets with constant requests, predict them, wait for them
    task automatic run_round(input logic [15:0] r, input logic m, input int k);
        int w, got, bud;
        sp0_wrr1 = m;
        req      = r;
        for (int n = 0; n < k; n++) begin
            w = model_pick(r, m);
            sb.push_back('{w, (tb_len[w] == 0) ? 1 : int'(tb_len[w])});
        end
        got = 0;
        bud = 0;
        while (got < k && bud < 2000) begin
            @(negedge clk); #1;
            bud++;
            if (pkt_done) got++;
        end
        check("round_packets_done", got, k);
        if (got < k) sb.delete();
    endtask

    task automatic idle_round(input int cyc);
        req = '0;
        repeat (cyc) begin @(negedge clk); #1; end
        check("idle_busy", int'(busy), 0);
        check("idle_gnt", int'(gnt), 0);
        check("idle_sb_empty", sb.size(), 0);
    endtask

    // SRAM acceptance driver
    initial begin
        logic [7:0] pat;
        int pidx;
        pat  = 8'b1101_1001;
        pidx = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       sram_ready = 1'b1;
                2:       sram_ready = pat[pidx % 8];
                default: sram_ready = ($urandom_range(0, 3) != 0);
            endcase
            pidx++;
        end
    end

    // monitor: framing checks every cycle, scoreboard compare on pkt_done
    initial begin
        int beats;
        logic d1, d2;
        exp_t e;
        beats = 0; d1 = 1'b0; d2 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                beats = 0; d1 = 1'b0; d2 = 1'b0;
            end else begin
                if (gnt != '0) check("gnt_onehot_matches_select", int'(gnt), 1 << select);
                if (d2) check("idle_after_gap_busy", int'(busy), 0);
                if (d1) begin
                    check("gap_gnt", int'(gnt), 0);
                    check("gap_busy", int'(busy), 1);
                    check("gap_wr_en", int'(wr_en), 0);
                end
                d2 = d1;
                d1 = 1'b0;
                if (wr_en) begin
                    beats++;
                    check("beat_busy", int'(busy), 1);
                    check("beat_gnt_held", int'(gnt != '0), 1);
                end
                if (pkt_done) begin
                    check("done_with_wr_en", int'(wr_en), 1);
                    if (sb.size() == 0) begin
                        check("unexpected_packet_port", int'(select), -1);
                    end else begin
                        e = sb.pop_front();
                        check("packet_port", int'(select), e.port);
                        check("packet_beats", beats, e.len);
                    end
                    beats = 0;
                    d1 = 1'b1;
                end
            end
        end
    end

    // stimulus
    initial begin
        logic [15:0] r;
        rst = 1'b0;
        model_reset();
        repeat (3) begin @(negedge clk); #1; end
        check("reset_gnt", int'(gnt), 0);
        check("reset_select", int'(select), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_wr_en", int'(wr_en), 0);
        rst = 1'b1;

        // SP tie on priority 3: port 0 first, then port 2 alone
        tb_len = {16{8'd4}};
        tb_prio = '0;
        tb_prio[0] = 3'd3;
        tb_prio[2] = 3'd3;
        run_round(16'h0005, 1'b0, 1);
        run_round(16'h0004, 1'b0, 1);

        // SP: port 15 at 7 beats port 0 at 6
        tb_prio = '0;
        tb_prio[15] = 3'd7;
        tb_prio[0]  = 3'd6;
        run_round(16'h8001, 1'b0, 2);

        // WRR, all requesting, port 3 weighted 2, single-word packets
        tb_prio = '0;
        tb_prio[3] = 3'd2;
        tb_len = {16{8'd1}};
        run_round(16'hFFFF, 1'b1, 21);

        // backpressure pattern on a 5-word packet
        idle_round(3);
        rdy_mode = 2;
        tb_len = {16{8'd5}};
        run_round(16'h0040, 1'b0, 1);
        rdy_mode = 0;

        // zero length is a single word
        tb_len[9] = 8'd0;
        run_round(16'h0200, 1'b0, 1);

        // reset in the 3rd transfer cycle of an 8-word packet
        idle_round(3);
        rdy_mode = 1;
        tb_len = {16{8'd8}};
        tb_prio = '0;
        sp0_wrr1 = 1'b1;
        req = 16'hFFFF;
        @(negedge clk); #1;
        check("abort_granted", int'(gnt != '0), 1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk); #1;
        check("abort_gnt", int'(gnt), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_pkt_done", int'(pkt_done), 0);
        rst = 1'b1;
        model_reset();
        rdy_mode = 0;
        run_round(16'hFFFF, 1'b1, 3);

        // randomized rounds
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 16; i++) begin
                tb_prio[i] = 3'($urandom_range(0, 7));
                tb_len[i]  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 10));
            end
            r = 16'($urandom) & 16'($urandom);
            if (r == '0 || $urandom_range(0, 9) == 0)
                idle_round(4);
            else
                run_round(r, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
        end

        idle_round(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
